// File: rtl/cache_ctrl_assoc.sv
// ---------------------------------------------------------------------------
// cache_ctrl_assoc
//
// Controller for a 2-way set-associative, write-back, write-allocate cache.
// It keeps the per-set metadata ({valid, dirty, tag} per way, one LRU bit per
// set) and sequences the external data SRAM and the SDRAM. The data path
// itself lives outside this block and is steered by mux_sel/demux_sel.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   Address_cpu              CPU byte address {tag, index, offset}
//   wr_rd_cpu                1 = write, 0 = read
//   cs_cpu                   request strobe, only looked at while idle
//   rdy_cpu                  controller idle and able to take a request
//   Address_sdram            SDRAM word address for block transfers
//   wr_rd_sdram              1 = write-back to SDRAM, 0 = refill from SDRAM
//   mstrb_sdram              one-cycle strobe per transferred word
//   address_cache_ctrl_sram  data SRAM address {way, index, offset}
//   wen_sram                 data SRAM write enable
//   mux_sel                  SRAM write-data source: 0 = CPU, 1 = SDRAM
//   demux_sel                SRAM read-data sink: 0 = CPU, 1 = SDRAM
//   hit_cnt, miss_cnt        saturating lookup counters
// ---------------------------------------------------------------------------
module cache_ctrl_assoc #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             Address_cpu,
  input  logic                              wr_rd_cpu,
  input  logic                              cs_cpu,
  output logic                              rdy_cpu,
  output logic [ADDR_WIDTH-1:0]             Address_sdram,
  output logic                              wr_rd_sdram,
  output logic                              mstrb_sdram,
  output logic [INDEX_BITS+OFFSET_BITS:0]   address_cache_ctrl_sram,
  output logic                              wen_sram,
  output logic                              mux_sel,
  output logic                              demux_sel,
  output logic [CNT_WIDTH-1:0]              hit_cnt,
  output logic [CNT_WIDTH-1:0]              miss_cnt
);

  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int SETS     = 1 << INDEX_BITS;
  localparam logic [OFFSET_BITS-1:0] OFF_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    REFILL,
    ACCESS
  } state_t;

  state_t state;

  // Metadata: bit [w] of valid/dirty belongs to way w.
  logic [1:0]          valid [SETS];
  logic [1:0]          dirty [SETS];
  logic [TAG_BITS-1:0] tags  [SETS][2];
  logic [SETS-1:0]     lru;

  // Latched request.
  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_index;
  logic [OFFSET_BITS-1:0] req_offset;
  logic                   req_write;

  // Transfer bookkeeping.
  logic                   victim;
  logic                   access_way;
  logic [OFFSET_BITS-1:0] off_cnt;
  logic                   phase;

  // Lookup results for the latched request.
  logic                   hit0;
  logic                   hit1;
  logic                   hit_way;
  logic                   victim_sel;
  logic                   victim_dirty;
  logic [OFFSET_BITS-1:0] next_off;

  // Tag compare and victim choice for the set being looked up. An invalid
  // way is always preferred over evicting, way 0 first; only a full set
  // falls back to the LRU bit.
  always_comb begin
    hit0         = valid[req_index][0] && (tags[req_index][0] == req_tag);
    hit1         = valid[req_index][1] && (tags[req_index][1] == req_tag);
    hit_way      = hit0 ? 1'b0 : 1'b1;
    victim_sel   = 1'b0;
    if (!valid[req_index][0]) begin
      victim_sel = 1'b0;
    end else if (!valid[req_index][1]) begin
      victim_sel = 1'b1;
    end else begin
      victim_sel = lru[req_index];
    end
    victim_dirty = valid[req_index][victim_sel] && dirty[req_index][victim_sel];
    next_off     = off_cnt + 1'b1;
  end

  // Main controller. Every output is a register, so each transition loads
  // the values the next state shows in its first cycle. Block transfers
  // run two cycles per word: phase 0 presents the addresses, phase 1 fires
  // the strobes, then the offset advances or the state is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      rdy_cpu                 <= 1'b0;
      Address_sdram           <= '0;
      wr_rd_sdram             <= 1'b0;
      mstrb_sdram             <= 1'b0;
      address_cache_ctrl_sram <= '0;
      wen_sram                <= 1'b0;
      mux_sel                 <= 1'b0;
      demux_sel               <= 1'b0;
      hit_cnt                 <= '0;
      miss_cnt                <= '0;
      req_tag                 <= '0;
      req_index               <= '0;
      req_offset              <= '0;
      req_write               <= 1'b0;
      victim                  <= 1'b0;
      access_way              <= 1'b0;
      off_cnt                 <= '0;
      phase                   <= 1'b0;
      lru                     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= 2'b00;
        dirty[s] <= 2'b00;
      end
    end else begin
      mstrb_sdram <= 1'b0;
      wen_sram    <= 1'b0;

      case (state)
        IDLE: begin
          Address_sdram           <= '0;
          wr_rd_sdram             <= 1'b0;
          address_cache_ctrl_sram <= '0;
          mux_sel                 <= 1'b0;
          demux_sel               <= 1'b0;
          if (cs_cpu) begin
            req_tag    <= Address_cpu[ADDR_WIDTH-1 -: TAG_BITS];
            req_index  <= Address_cpu[OFFSET_BITS +: INDEX_BITS];
            req_offset <= Address_cpu[OFFSET_BITS-1:0];
            req_write  <= wr_rd_cpu;
            rdy_cpu    <= 1'b0;
            state      <= COMPARE;
          end else begin
            rdy_cpu <= 1'b1;
          end
        end

        COMPARE: begin
          off_cnt <= '0;
          phase   <= 1'b0;
          if (hit0 || hit1) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            access_way              <= hit_way;
            address_cache_ctrl_sram <= {hit_way, req_index, req_offset};
            wen_sram                <= req_write;
            mux_sel                 <= 1'b0;
            demux_sel               <= 1'b0;
            state                   <= ACCESS;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            victim                  <= victim_sel;
            address_cache_ctrl_sram <= {victim_sel, req_index, OFF_ZERO};
            if (victim_dirty) begin
              Address_sdram <= {tags[req_index][victim_sel], req_index, OFF_ZERO};
              wr_rd_sdram   <= 1'b1;
              demux_sel     <= 1'b1;
              mux_sel       <= 1'b0;
              state         <= WRITEBACK;
            end else begin
              Address_sdram <= {req_tag, req_index, OFF_ZERO};
              wr_rd_sdram   <= 1'b0;
              mux_sel       <= 1'b1;
              demux_sel     <= 1'b0;
              state         <= REFILL;
            end
          end
        end

        WRITEBACK: begin
          if (!phase) begin
            phase       <= 1'b1;
            mstrb_sdram <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (off_cnt == '1) begin
              off_cnt                 <= '0;
              dirty[req_index][victim] <= 1'b0;
              Address_sdram           <= {req_tag, req_index, OFF_ZERO};
              wr_rd_sdram             <= 1'b0;
              mux_sel                 <= 1'b1;
              demux_sel               <= 1'b0;
              address_cache_ctrl_sram <= {victim, req_index, OFF_ZERO};
              state                   <= REFILL;
            end else begin
              off_cnt                 <= next_off;
              Address_sdram           <= {tags[req_index][victim], req_index, next_off};
              address_cache_ctrl_sram <= {victim, req_index, next_off};
            end
          end
        end

        REFILL: begin
          if (!phase) begin
            phase       <= 1'b1;
            mstrb_sdram <= 1'b1;
            wen_sram    <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (off_cnt == '1) begin
              off_cnt                  <= '0;
              valid[req_index][victim] <= 1'b1;
              dirty[req_index][victim] <= 1'b0;
              tags[req_index][victim]  <= req_tag;
              access_way               <= victim;
              Address_sdram            <= '0;
              wr_rd_sdram              <= 1'b0;
              mux_sel                  <= 1'b0;
              demux_sel                <= 1'b0;
              address_cache_ctrl_sram  <= {victim, req_index, req_offset};
              wen_sram                 <= req_write;
              state                    <= ACCESS;
            end else begin
              off_cnt                 <= next_off;
              Address_sdram           <= {req_tag, req_index, next_off};
              address_cache_ctrl_sram <= {victim, req_index, next_off};
            end
          end
        end

        ACCESS: begin
          if (req_write) dirty[req_index][access_way] <= 1'b1;
          lru[req_index]          <= ~access_way;
          address_cache_ctrl_sram <= '0;
          rdy_cpu                 <= 1'b1;
          state                   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_assoc
//
// Drives cache_ctrl_assoc with directed and random CPU requests and compares
// every SDRAM word strobe, the final SRAM access, the latency and the
// counters against a reference cache model held in plain arrays. A second
// instance with 2-bit counters shares all inputs so counter saturation gets
// exercised without long runs.
// ---------------------------------------------------------------------------
module tb_cache_ctrl_assoc;

  localparam int AW  = 16;
  localparam int IB  = 3;
  localparam int OB  = 5;
  localparam int CW  = 16;
  localparam int BLK = 1 << OB;
  localparam int SAT_MAX = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] Address_cpu;
  logic          wr_rd_cpu;
  logic          cs_cpu;

  logic          rdy_cpu;
  logic [AW-1:0] Address_sdram;
  logic          wr_rd_sdram;
  logic          mstrb_sdram;
  logic [IB+OB:0] address_cache_ctrl_sram;
  logic          wen_sram;
  logic          mux_sel;
  logic          demux_sel;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  logic          s_rdy_cpu;
  logic [AW-1:0] s_Address_sdram;
  logic          s_wr_rd_sdram;
  logic          s_mstrb_sdram;
  logic [IB+OB:0] s_address_cache_ctrl_sram;
  logic          s_wen_sram;
  logic          s_mux_sel;
  logic          s_demux_sel;
  logic [1:0]    s_hit_cnt;
  logic [1:0]    s_miss_cnt;

  int checks = 0;
  int errors = 0;

  // Reference cache state.
  bit mValid [8][2];
  bit mDirty [8][2];
  int mTag   [8][2];
  int mLru   [8];
  int mHits;
  int mMisses;

  always #5 clk = ~clk;

  cache_ctrl_assoc #(
    .ADDR_WIDTH(AW), .INDEX_BITS(IB), .OFFSET_BITS(OB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .Address_cpu(Address_cpu), .wr_rd_cpu(wr_rd_cpu),
    .cs_cpu(cs_cpu), .rdy_cpu(rdy_cpu), .Address_sdram(Address_sdram),
    .wr_rd_sdram(wr_rd_sdram), .mstrb_sdram(mstrb_sdram),
    .address_cache_ctrl_sram(address_cache_ctrl_sram), .wen_sram(wen_sram),
    .mux_sel(mux_sel), .demux_sel(demux_sel), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  cache_ctrl_assoc #(
    .ADDR_WIDTH(AW), .INDEX_BITS(IB), .OFFSET_BITS(OB), .CNT_WIDTH(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .Address_cpu(Address_cpu), .wr_rd_cpu(wr_rd_cpu),
    .cs_cpu(cs_cpu), .rdy_cpu(s_rdy_cpu), .Address_sdram(s_Address_sdram),
    .wr_rd_sdram(s_wr_rd_sdram), .mstrb_sdram(s_mstrb_sdram),
    .address_cache_ctrl_sram(s_address_cache_ctrl_sram), .wen_sram(s_wen_sram),
    .mux_sel(s_mux_sel), .demux_sel(s_demux_sel), .hit_cnt(s_hit_cnt),
    .miss_cnt(s_miss_cnt)
  );

  // One comparison: count it, report it if it differs.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Word strobe fingerprint: {sdram addr, sdram dir, sram addr, wen, data select}.
  function automatic logic [63:0] packPulse(int a, int w, int s, int we, int sel);
    return (64'(a) << 12) | (64'(w) << 11) | (64'(s) << 2) | (64'(we) << 1) | 64'(sel);
  endfunction

  function automatic int satCount(int n);
    return (n > SAT_MAX) ? SAT_MAX : n;
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 2; w++) begin
        mValid[s][w] = 1'b0;
        mDirty[s][w] = 1'b0;
        mTag[s][w]   = 0;
      end
      mLru[s] = 0;
    end
    mHits   = 0;
    mMisses = 0;
  endtask

  // Reset for a few cycles, check the cleared outputs, release and check
  // that the controller reports ready one cycle later.
  task automatic doReset();
    rst = 1'b1;
    cs_cpu = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {rdy_cpu, mstrb_sdram, wen_sram, hit_cnt, miss_cnt, Address_sdram,
                 address_cache_ctrl_sram, wr_rd_sdram, mux_sel, demux_sel}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", rdy_cpu, 1);
    modelReset();
  endtask

  // Issue one request at a negedge, follow it to completion and compare
  // everything it produced with what the model predicts.
  task automatic applyStimulus(input logic [15:0] addr, input bit wr);
    int tag, idx, off, way, victim, vtag, expLat, j, pulseCnt;
    bit hit, wb, done;
    logic [63:0] expQ [$];
    logic [63:0] acc;

    tag = int'(addr) / 256;
    idx = (int'(addr) / 32) % 8;
    off = int'(addr) % 32;
    hit = 1'b0;
    way = 0;
    wb  = 1'b0;
    for (int w = 1; w >= 0; w--) begin
      if (mValid[idx][w] && mTag[idx][w] == tag) begin
        hit = 1'b1;
        way = w;
      end
    end
    if (hit) begin
      mHits++;
      expLat = 3;
    end else begin
      mMisses++;
      if (!mValid[idx][0]) victim = 0;
      else if (!mValid[idx][1]) victim = 1;
      else victim = mLru[idx];
      wb   = mValid[idx][victim] && mDirty[idx][victim];
      vtag = mTag[idx][victim];
      if (wb) begin
        for (int k = 0; k < BLK; k++)
          expQ.push_back(packPulse(vtag * 256 + idx * 32 + k, 1, victim * 256 + idx * 32 + k, 0, 1));
      end
      for (int k = 0; k < BLK; k++)
        expQ.push_back(packPulse(tag * 256 + idx * 32 + k, 0, victim * 256 + idx * 32 + k, 1, 1));
      mValid[idx][victim] = 1'b1;
      mDirty[idx][victim] = 1'b0;
      mTag[idx][victim]   = tag;
      way = victim;
      expLat = 3 + (wb ? 4 : 2) * BLK;
    end
    if (wr) mDirty[idx][way] = 1'b1;
    mLru[idx] = 1 - way;

    j = 0;
    while (!rdy_cpu && j < 400) begin
      @(negedge clk);
      j++;
    end
    checkOutput("ready_before_request", rdy_cpu, 1);

    cs_cpu      = 1'b1;
    Address_cpu = addr;
    wr_rd_cpu   = wr;
    @(posedge clk);
    @(negedge clk);
    cs_cpu      = 1'b0;
    Address_cpu = AW'($urandom);
    wr_rd_cpu   = 1'($urandom);
    checkOutput("compare_cycle_outputs", {rdy_cpu, mstrb_sdram, wen_sram}, 0);

    // Busy period: cs_cpu is wiggled to show it is ignored.
    acc      = '0;
    pulseCnt = 0;
    done     = 1'b0;
    j        = 0;
    while (!done && j < 400) begin
      @(negedge clk);
      j++;
      if (rdy_cpu) begin
        done   = 1'b1;
        cs_cpu = 1'b0;
      end else begin
        cs_cpu = 1'($urandom);
        if (mstrb_sdram) begin
          if (pulseCnt < expQ.size())
            checkOutput($sformatf("word_%0d_of_0x%0h", pulseCnt, addr),
                        packPulse(int'(Address_sdram), int'(wr_rd_sdram),
                                  int'(address_cache_ctrl_sram), int'(wen_sram),
                                  int'(wr_rd_sdram ? demux_sel : mux_sel)),
                        expQ[pulseCnt]);
          pulseCnt++;
        end
        acc = {54'd0, address_cache_ctrl_sram, wen_sram, (wr ? mux_sel : demux_sel)};
      end
    end
    cs_cpu = 1'b0;

    checkOutput($sformatf("latency_0x%0h", addr), done ? j + 1 : 0, expLat);
    checkOutput($sformatf("strobe_count_0x%0h", addr), pulseCnt, expQ.size());
    checkOutput($sformatf("access_0x%0h", addr), acc,
                64'(((way * 256 + idx * 32 + off) << 2) | (int'(wr) << 1)));
    checkOutput("idle_strobes", {mstrb_sdram, wen_sram}, 0);
    checkOutput("hit_cnt", hit_cnt, mHits);
    checkOutput("miss_cnt", miss_cnt, mMisses);
    checkOutput("hit_cnt_saturating", s_hit_cnt, satCount(mHits));
    checkOutput("miss_cnt_saturating", s_miss_cnt, satCount(mMisses));
  endtask

  int tagPool [4] = '{8'h12, 8'h56, 8'h9A, 8'hBC};

  initial begin
    int pulses, g, tg;
    rst         = 1'b1;
    cs_cpu      = 1'b0;
    Address_cpu = '0;
    wr_rd_cpu   = 1'b0;
    modelReset();
    @(negedge clk);
    doReset();

    // Abort a refill with reset just before the strobe of word 10.
    cs_cpu      = 1'b1;
    Address_cpu = 16'h1234;
    wr_rd_cpu   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cs_cpu = 1'b0;
    pulses = 0;
    g      = 0;
    while (pulses < 10 && g < 300) begin
      @(negedge clk);
      g++;
      if (mstrb_sdram) pulses++;
    end
    checkOutput("abort_reached_word_10", pulses, 10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_outputs", {mstrb_sdram, wen_sram, rdy_cpu, miss_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_abort", rdy_cpu, 1);
    modelReset();

    // Directed walk through one set.
    applyStimulus(16'h1234, 1'b0);
    checkOutput("first_read_miss_cnt", miss_cnt, 1);
    applyStimulus(16'h1234, 1'b0);
    checkOutput("repeat_read_hit_cnt", hit_cnt, 1);
    applyStimulus(16'h5634, 1'b1);
    applyStimulus(16'h9A34, 1'b0);
    applyStimulus(16'hBC34, 1'b0);

    // Random traffic over a small tag pool so hits, clean and dirty
    // evictions all occur.
    for (int n = 0; n < 60; n++) begin
      tg = ($urandom_range(0, 4) == 4) ? int'($urandom_range(0, 255)) : tagPool[$urandom_range(0, 3)];
      applyStimulus(16'(tg * 256 + int'($urandom_range(0, 7)) * 32 + int'($urandom_range(0, 31))),
                    1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_assoc.md
CACHE_CTRL_ASSOC -- requirements
Module: cache_ctrl_assoc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, CPU/SDRAM byte-address width.
REQ-002 SHALL have parameter INDEX_BITS, default 3, set-index width (2^INDEX_BITS sets).
REQ-003 SHALL have parameter OFFSET_BITS, default 5, word offset in block (BLK = 2^OFFSET_BITS words).
REQ-004 SHALL have parameter CNT_WIDTH, default 16, hit/miss counter width; TAG_BITS = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 Address_cpu  in  ADDR_WIDTH  CPU address {tag,index,offset}.
REQ-008 wr_rd_cpu  in  1  1=write, 0=read.
REQ-009 cs_cpu  in  1  request strobe.
REQ-010 rdy_cpu  out  1  controller idle, accepts request.
REQ-011 Address_sdram  out  ADDR_WIDTH  SDRAM word address.
REQ-012 wr_rd_sdram  out  1  1=SDRAM write (write-back), 0=read (refill).
REQ-013 mstrb_sdram  out  1  one-cycle SDRAM word strobe.
REQ-014 address_cache_ctrl_sram  out  1+INDEX_BITS+OFFSET_BITS  data SRAM address {way,index,offset}.
REQ-015 wen_sram  out  1  data SRAM write enable.
REQ-016 mux_sel  out  1  SRAM write-data source: 0=CPU, 1=SDRAM.
REQ-017 demux_sel  out  1  SRAM read-data sink: 0=CPU, 1=SDRAM.
REQ-018 hit_cnt, miss_cnt  out  CNT_WIDTH each  saturating lookup counters.

Function
REQ-019 SHALL be 2-way set-associative, write-back, write-allocate; per set per way {valid,dirty,tag}; one LRU bit per set naming least-recently-used way.
REQ-020 SHALL use FSM states IDLE, COMPARE, WRITEBACK, REFILL, ACCESS; all outputs registered.
REQ-021 IDLE: rdy_cpu=1; cs_cpu=1 at edge T latches Address_cpu and wr_rd_cpu, goes COMPARE; rdy_cpu=0 from T+1 until return to IDLE; cs_cpu ignored outside IDLE.
REQ-022 COMPARE (1 cycle): hit if valid and tag equal in either way -> ACCESS, hit_cnt+1; else miss_cnt+1, victim chosen, -> WRITEBACK if victim valid and dirty else REFILL.
REQ-023 Victim: first invalid way (way 0 before way 1); if both valid, way named by LRU.
REQ-024 Each block transfer SHALL take 2*BLK cycles, 2 per word, offsets 0..BLK-1 ascending: phase 0 drives addresses; phase 1 mstrb_sdram=1 for exactly one cycle.
REQ-025 WRITEBACK: Address_sdram={victim tag,index,offset}, wr_rd_sdram=1, demux_sel=1, SRAM address {victim,index,offset}; after last word victim dirty=0, -> REFILL.
REQ-026 REFILL: Address_sdram={req tag,index,offset}, wr_rd_sdram=0, mux_sel=1, wen_sram=1 in phase 1; after last word victim way valid=1, dirty=0, tag=req tag, -> ACCESS.
REQ-027 ACCESS (1 cycle): SRAM address {hit/filled way,index,req offset}; write: wen_sram=1, mux_sel=0, dirty=1; read: wen_sram=0, demux_sel=0; LRU set to other way; -> IDLE.
REQ-028 Latency, request at T: hit rdy_cpu=1 at T+3; clean miss T+3+2*BLK; dirty miss T+3+4*BLK.
REQ-029 wen_sram and mstrb_sdram SHALL be 0 in IDLE and COMPARE.
REQ-030 hit_cnt/miss_cnt SHALL saturate at all-ones, never wrap.
REQ-031 Tag/offset arithmetic unsigned; offset counter wraps to 0 only at state exit.

Reset
REQ-032 rst=1 at an edge SHALL force next cycle: IDLE, rdy_cpu=0, all valid/dirty/LRU=0, counters=0, all other outputs 0; rdy_cpu=1 first cycle after rst falls.
REQ-033 rst mid-transfer SHALL abort immediately: no further mstrb_sdram or wen_sram pulse, no write-back completion.

Verification (defaults, BLK=32)
REQ-034 After reset, read 0x1234 at T -> 32 mstrb read pulses, Address_sdram 0x1220..0x123F, wen_sram at SRAM 0x020..0x03F; rdy_cpu=1 at T+67; miss_cnt=1.
REQ-035 Repeat read 0x1234 -> no mstrb_sdram, SRAM addr 0x034, rdy_cpu=1 at T+3, hit_cnt=1.
REQ-036 Write 0x5634 -> refill way 1; ACCESS wen_sram=1, mux_sel=0, SRAM addr 0x134; way1 set1 dirty=1.
REQ-037 Read 0x9A34 -> evicts clean way 0, no write-back; then read 0xBC34 -> evicts dirty way 1: 32 pulses wr_rd_sdram=1, Address_sdram 0x5620..0x563F, demux_sel=1, then refill; rdy at T+131.
REQ-038 rst=1 during REFILL word 10 -> mstrb_sdram=0 next cycle; subsequent read 0x1234 misses (miss_cnt=1 after reset).
